// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, data/frame sizes and the baud-period helper.
// Build option: define UART_TX_PARITY_EN for 8E1 frames (adds the PARITY state and
// lengthens the frame to 11 symbols); leave it undefined for plain 8N1.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned UART_FRAME_SYMBOLS = 11;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
`else
  localparam int unsigned UART_FRAME_SYMBOLS = 10;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_state_e;
`endif

  // Clock cycles per symbol, floor division.
  function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                   input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Symbol timer shared by the UART transmitter and receiver.
// Ports:
//   clk         in  system clock
//   rst         in  asynchronous active-low reset
//   run         in  count while high; held at OFFSET while low
//   symbol_edge out one-cycle pulse in the last cycle of each PERIOD-cycle symbol
// OFFSET lets the receiver start half a period in so it samples mid-symbol.
module uart_baud_counter #(
  parameter int unsigned PERIOD = 434,
  parameter int unsigned OFFSET = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic symbol_edge
);

  localparam int unsigned WIDTH = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(PERIOD - 1);
  localparam logic [WIDTH-1:0] START = WIDTH'(OFFSET);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= START;
    end else if (!run) begin
      r_count <= START;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  // Pulse coincides with the wrap so the FSM advances on the same edge the count restarts.
  assign symbol_edge = run && (r_count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: accepts one byte over ready/valid and shifts it out LSB-first.
// Ports:
//   clk           in  system clock
//   rst           in  asynchronous active-low reset
//   data_in       in  byte to send, captured only on handshake
//   data_in_valid in  producer has a byte
//   data_in_ready out high only while idle
//   serial_out    out UART line, idle high, driven straight from a flop
// Build option: UART_TX_PARITY_EN inserts an even-parity symbol before stop (8E1).
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] data_in,
  input  logic                      data_in_valid,
  output logic                      data_in_ready,
  output logic                      serial_out
);

  localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  uart_state_e               r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]          r_bit_idx;
  logic                      r_serial_out;
  logic                      r_ready;

  logic             w_run;
  logic             w_symbol_edge;
  logic [IDX_W-1:0] w_next_idx;

  assign w_run      = (r_state != IDLE);
  assign w_next_idx = r_bit_idx + IDX_W'(1);

  uart_baud_counter #(
    .PERIOD(SYMBOL_EDGE_TIME),
    .OFFSET(0)
  ) u_baud_counter (
    .clk        (clk),
    .rst        (rst),
    .run        (w_run),
    .symbol_edge(w_symbol_edge)
  );

  // Outputs are loaded with the level of the state being entered, so serial_out
  // always matches the current state without any decode after the flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_serial_out <= 1'b1;
      r_ready      <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (data_in_valid) begin
            r_shift      <= data_in;
            r_bit_idx    <= '0;
            r_state      <= START;
            r_serial_out <= 1'b0;
            r_ready      <= 1'b0;
          end
        end
        START: begin
          if (w_symbol_edge) begin
            r_state      <= DATA;
            r_serial_out <= r_shift[0];
          end
        end
        DATA: begin
          if (w_symbol_edge) begin
            if (r_bit_idx == LAST_IDX) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state      <= PARITY;
              r_serial_out <= ^r_shift;
`else
              r_state      <= STOP;
              r_serial_out <= 1'b1;
`endif
            end else begin
              r_bit_idx    <= w_next_idx;
              r_serial_out <= r_shift[w_next_idx];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_symbol_edge) begin
            r_state      <= STOP;
            r_serial_out <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_symbol_edge) begin
            r_state      <= IDLE;
            r_serial_out <= 1'b1;
            r_ready      <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_bit_idx    <= '0;
          r_serial_out <= 1'b1;
          r_ready      <= 1'b1;
        end
      endcase
    end
  end

  assign serial_out    = r_serial_out;
  assign data_in_ready = r_ready;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter at 50 MHz / 115200 baud (434 cycles per symbol).
// Build option: define UART_TX_PARITY_EN to check 8E1 frames instead of 8N1.
module tb_uart_transmitter;

  localparam int SYM = 434;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];

  uart_transmitter #(
    .CLOCK_FREQ(50_000_000),
    .BAUD_RATE (115_200)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] data;
    bit         scramble;
    bit         hold;
    logic       exp_par;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference line levels for one frame: start, 8 data bits LSB first, [even parity], stop.
  task automatic build_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(((b >> i) & 8'd1) != 0);
      ones += int'((b >> i) & 8'd1);
    end
`ifdef UART_TX_PARITY_EN
    exp_q.push_back((ones % 2) == 1);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Called just after the handshake edge. Checks every cycle of every symbol, decodes the
  // byte mid-symbol like a receiver, then checks the single idle-high gap cycle.
  task automatic check_frame(input logic [7:0] b, input bit scramble, input bit keep,
                             input logic [7:0] nxt, output logic par_seen);
    int         bad;
    int         rdy_bad;
    logic [7:0] rx;
    rdy_bad  = 0;
    rx       = 8'h00;
    par_seen = 1'b0;
    build_frame(b);
    for (int k = 0; k < exp_q.size(); k++) begin
      bad = 0;
      for (int c = 0; c < SYM; c++) begin
        @(negedge clk);
        if (serial_out !== exp_q[k]) bad++;
        if (data_in_ready !== 1'b0) rdy_bad++;
        if (c == SYM / 2) begin
          if (k >= 1 && k <= 8) rx[k-1] = serial_out;
          if (k == 9) par_seen = serial_out;
        end
        if (k == exp_q.size() - 1 && c == SYM - 1) begin
          data_in_valid = keep;
          data_in       = nxt;
        end else if (scramble) begin
          data_in       = 8'($urandom);
          data_in_valid = 1'($urandom);
        end
      end
      check($sformatf("byte %02h symbol %0d cycles at wrong level", b, k), bad, 0);
    end
    check($sformatf("byte %02h cycles with ready high mid-frame", b), rdy_bad, 0);
    check($sformatf("byte %02h decoded", b), rx, b);
    @(negedge clk);
    check("idle gap serial_out", serial_out, 1);
    check("idle gap data_in_ready", data_in_ready, 1);
  endtask

  task automatic check_idle(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || data_in_ready !== 1'b1) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic handshake(input logic [7:0] b);
    data_in       = b;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       vecs[9];
    bit         pending;
    bit         keep;
    logic [7:0] nxt;
    logic       par;
    logic [7:0] b;
    bit         scr;

    vecs[0] = '{data: 8'h55, scramble: 1'b0, hold: 1'b0, exp_par: 1'b0};
    vecs[1] = '{data: 8'hA3, scramble: 1'b0, hold: 1'b1, exp_par: 1'b0};
    vecs[2] = '{data: 8'h0F, scramble: 1'b0, hold: 1'b0, exp_par: 1'b0};
    vecs[3] = '{data: 8'h3C, scramble: 1'b1, hold: 1'b0, exp_par: 1'b0};
    vecs[4] = '{data: 8'h07, scramble: 1'b0, hold: 1'b0, exp_par: 1'b1};
    vecs[5] = '{data: 8'h03, scramble: 1'b0, hold: 1'b0, exp_par: 1'b0};
    vecs[6] = '{data: 8'h80, scramble: 1'b1, hold: 1'b0, exp_par: 1'b1};
    vecs[7] = '{data: 8'h7E, scramble: 1'b0, hold: 1'b1, exp_par: 1'b0};
    vecs[8] = '{data: 8'hFF, scramble: 1'b0, hold: 1'b0, exp_par: 1'b0};

    rst           = 1'b0;
    data_in       = 8'h00;
    data_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset serial_out", serial_out, 1);
    check("reset data_in_ready", data_in_ready, 1);
    rst = 1'b1;
    check_idle("idle after reset release", 4);

    pending = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (pending) begin
        @(posedge clk);
        #1;
      end else begin
        handshake(vecs[i].data);
      end
      if (!vecs[i].hold) data_in_valid = 1'b0;
      keep = vecs[i].hold && (i + 1 < 9);
      nxt  = (i + 1 < 9) ? vecs[i+1].data : 8'h00;
      check_frame(vecs[i].data, vecs[i].scramble, keep, nxt, par);
`ifdef UART_TX_PARITY_EN
      check($sformatf("byte %02h parity bit", vecs[i].data), par, vecs[i].exp_par);
`endif
      pending = keep;
      if (!keep) check_idle($sformatf("no extra frame after %02h", vecs[i].data), 3);
    end

    for (int r = 0; r < 3; r++) begin
      b   = 8'($urandom);
      scr = 1'($urandom);
      handshake(b);
      data_in_valid = 1'b0;
      check_frame(b, scr, 1'b0, 8'h00, par);
`ifdef UART_TX_PARITY_EN
      check($sformatf("random %02h parity bit", b), par, 1'($countones(b) % 2));
`endif
      check_idle($sformatf("no extra frame after random %02h", b), 3);
    end

    // Reset in the middle of a frame of zeros: line must go high before the next edge.
    handshake(8'h00);
    data_in_valid = 1'b0;
    repeat (999) @(negedge clk);
    check("mid-frame line before reset", serial_out, 0);
    check("mid-frame ready before reset", data_in_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async reset serial_out", serial_out, 1);
    check("async reset data_in_ready", data_in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    check_idle("frame abandoned after reset", 5);
    handshake(8'hFF);
    data_in_valid = 1'b0;
    check_frame(8'hFF, 1'b0, 1'b0, 8'h00, par);
`ifdef UART_TX_PARITY_EN
    check("byte ff after reset parity bit", par, 0);
`endif
    check_idle("idle at end", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit side of the CPU's UART, driving the `serial_out` pin of `cpu`. It accepts one byte at a time from the CPU's memory-mapped UART control logic over a ready/valid handshake. It then shifts the byte out LSB-first as an 8N1 frame (optionally 8E1) at a fixed baud rate derived from `CPU_CLOCK_FREQ`. It is the counterpart of the existing receiver on `serial_in`. The bench uses it to feed the receiver in loopback.

## Interface
- `CLOCK_FREQ`, default 50_000_000: clock frequency in Hz, tied to the CPU's `CPU_CLOCK_FREQ`.
- `BAUD_RATE`, default 115_200: line rate in bits/s.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to `clk` upstream.
- `data_in`  in  8  byte to send, sampled only on handshake.
- `data_in_valid`  in  1  producer has a byte.
- `data_in_ready`  out  1  transmitter can accept a byte this cycle.
- `serial_out`  out  1  UART line, idle high.

## Operation
- `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE`, using integer floor division. For the defaults this is 434.
- Counter width is `$clog2(SYMBOL_EDGE_TIME)`. The counter runs from 0 to `SYMBOL_EDGE_TIME-1`, then wraps to 0 and generates a one-cycle `symbol_edge` pulse.
- Handshake: a transfer occurs on any rising edge where `data_in_valid && data_in_ready`. The byte is latched into the shift register, and `data_in` is ignored at all other times.
- `data_in_ready` is high only in IDLE. `data_in_valid` may be held high across frames; each accepted cycle sends exactly one byte.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE → START on handshake.
  - START → DATA on `symbol_edge`.
  - DATA holds for 8 symbols, bit index 0..7 (LSB first). It then goes to PARITY or STOP on the 8th `symbol_edge`.
  - PARITY → STOP on `symbol_edge`.
  - STOP → IDLE on `symbol_edge`.
- `serial_out` per state:
  - IDLE = 1
  - START = 0
  - DATA = `shift[bit_idx]`
  - PARITY = even-parity bit, `^byte`
  - STOP = 1
- The baud counter is held at 0 in IDLE and starts counting on the cycle after the handshake. Every symbol therefore lasts exactly `SYMBOL_EDGE_TIME` cycles.
- Reset mid-frame: `serial_out` returns to 1 immediately (asynchronously), the FSM goes to IDLE, and the counter and bit index clear. The partial frame is abandoned and is not resumed.
- `data_in_valid` dropping or changing mid-frame has no effect.

## Timing
- Reset values:
  - `serial_out` = 1
  - `data_in_ready` = 1
  - state IDLE
  - counter 0, bit index 0, shift register 0
- Handshake at edge T: the start bit appears on `serial_out` from T (registered output, visible in the cycle after T). `data_in_ready` is 0 from T.
- Frame length is F = 10 symbols (11 with parity), i.e. F × `SYMBOL_EDGE_TIME` cycles, from edge T to the edge that ends STOP.
- `data_in_ready` rises at edge T + F×`SYMBOL_EDGE_TIME`. A back-to-back handshake can occur on the next edge, giving exactly one idle-high clock between frames.
- `serial_out` is glitch-free: it is driven directly from a flop, never from combinational decode.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined: the PARITY state is included, and an even-parity bit (XOR of the 8 data bits) is sent between bit 7 and stop. This gives an 8E1 frame of 11 symbols.
- Undefined: the PARITY state and its logic are absent. The frame is 8N1 with 10 symbols.
- The interface is identical in both builds. The receiver must be built with the same setting.

## Structure
- Package `uart_pkg` contains:
  - the state enum (`IDLE`, `START`, `DATA`, `PARITY`, `STOP`);
  - the function `symbol_edge_time(clock_freq, baud_rate)`;
  - the constants `UART_DATA_BITS = 8` and the frame-length constant, which depends on the macro.
- Sub-module `uart_baud_counter` has a parameter for the period, inputs `clk`, `rst`, and `run`, and output `symbol_edge`. It is shared with the receiver, which uses a half-period offset.

## Test plan
All scenarios use `CLOCK_FREQ`=50_000_000 and `BAUD_RATE`=115_200 (434 cycles/bit), with the macro off unless stated.

- **Single byte.** Send 0x55 → `serial_out` sequence is 0,1,0,1,0,1,0,1,0,1. Each level is held exactly 434 cycles. `data_in_ready` is low for exactly 4340 cycles, then high.
- **Back-to-back.** Hold `data_in_valid`=1 with 0xA3 then 0x0F → two frames, decoded LSB-first as 0xA3 then 0x0F. There is exactly one idle-high cycle between the stop of frame 1 and the start of frame 2.
- **Reset mid-frame.** Send 0x00 and assert `rst` low at cycle 1000 → `serial_out`=1 and `data_in_ready`=1 in the same cycle. After release, send 0xFF and get a clean frame 0,1×8,1.
- **Ignored input.** Change `data_in` and toggle `data_in_valid` during a frame → the transmitted byte equals the value latched at the handshake. No extra frame is sent.
- **Parity build.** With `UART_TX_PARITY_EN` defined, send 0x07 → parity bit 1, frame of 11 symbols = 4774 cycles. Send 0x03 → parity bit 0.
- **Loopback with receiver.** Connect `serial_out` to the receiver's `serial_in` and send 0x00, 0x7E, 0xFF → the receiver reports the same three bytes in order.
